// File: rtl/mod12_hour_display_if.sv
// Signal bundle between the mod-12 counter side and the hour display block.
interface mod12_hour_display_if;
    logic [3:0] q_in;
    logic       err_clr;
    logic [7:0] hour_bcd;
    logic       pm;
    logic       wrap_pulse;
    logic       seq_err;
    logic [1:0] an;
    logic [6:0] seg;

    modport slave (
        input  q_in, err_clr,
        output hour_bcd, pm, wrap_pulse, seq_err, an, seg
    );

    modport master (
        output q_in, err_clr,
        input  hour_bcd, pm, wrap_pulse, seq_err, an, seg
    );
endinterface

// File: rtl/mod12_hour_display.sv
// Maps a mod-12 count to a 12-hour BCD display with AM/PM tracking,
// sequence checking and a two-digit multiplexed seven-segment driver.
module mod12_hour_display #(
    parameter int unsigned REFRESH_DIV = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    mod12_hour_display_if.slave  bus
);

    logic [3:0]  q_r_q, q_r_d;
    logic [7:0]  hour_bcd_q, hour_bcd_d;
    logic        pm_q, pm_d;
    logic        wrap_pulse_q, wrap_pulse_d;
    logic        seq_err_q, seq_err_d;
    logic [15:0] refresh_q, refresh_d;
    logic        sel_q, sel_d;

    logic [3:0]  q_next;
    logic        in_range;
    logic        step_ok;
    logic        err_set;
    logic [3:0]  digit;

    function automatic logic [7:0] hour_of(input logic [3:0] q);
        logic [7:0] h;
        if (q == 4'd0)
            h = 8'h12;
        else if (q >= 4'd10)
            h = {4'h1, 4'(q - 4'd10)};
        else
            h = {4'h0, q};
        return h;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    always_comb begin
        q_r_d        = q_r_q;
        hour_bcd_d   = hour_bcd_q;
        pm_d         = pm_q;
        wrap_pulse_d = 1'b0;
        seq_err_d    = seq_err_q;
        refresh_d    = refresh_q + 16'd1;
        sel_d        = sel_q;

        q_next   = (q_r_q == 4'd11) ? 4'd0 : 4'(q_r_q + 4'd1);
        in_range = (bus.q_in <= 4'd11);
        step_ok  = (bus.q_in == q_r_q) || (bus.q_in == q_next);
        err_set  = !in_range || !step_ok;

        // Skips still resync to the new count; only out-of-range values hold.
        if (in_range) begin
            q_r_d      = bus.q_in;
            hour_bcd_d = hour_of(bus.q_in);
        end

        if (q_r_q == 4'd11 && bus.q_in == 4'd0) begin
            wrap_pulse_d = 1'b1;
            pm_d         = ~pm_q;
        end

        if (err_set)
            seq_err_d = 1'b1;
        else if (bus.err_clr)
            seq_err_d = 1'b0;

        if (refresh_q == 16'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            sel_d     = ~sel_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r_q        <= '0;
            hour_bcd_q   <= 8'h12;
            pm_q         <= 1'b0;
            wrap_pulse_q <= 1'b0;
            seq_err_q    <= 1'b0;
            refresh_q    <= '0;
            sel_q        <= 1'b0;
        end else begin
            q_r_q        <= q_r_d;
            hour_bcd_q   <= hour_bcd_d;
            pm_q         <= pm_d;
            wrap_pulse_q <= wrap_pulse_d;
            seq_err_q    <= seq_err_d;
            refresh_q    <= refresh_d;
            sel_q        <= sel_d;
        end
    end

    always_comb begin
        digit   = sel_q ? hour_bcd_q[7:4] : hour_bcd_q[3:0];
        bus.an  = sel_q ? 2'b10 : 2'b01;
        // Leading zero on the tens digit is blanked, digit enable stays on.
        bus.seg = (sel_q && digit == 4'd0) ? 7'h00 : seg_of(digit);
    end

    assign bus.hour_bcd   = hour_bcd_q;
    assign bus.pm         = pm_q;
    assign bus.wrap_pulse = wrap_pulse_q;
    assign bus.seq_err    = seq_err_q;

endmodule
